fsm_multi_timeout: RTL and testbench
====================================

Name: fsm_multi_timeout

Overview:
- Parametrised one-hot control FSM array: NUM_CH independent channels, each cycling IDLE -> BUSY -> WAIT -> BUSY/IDLE.
- Adds a per-channel WAIT timeout counter, a sticky ERROR state with software clear, and aggregate status outputs.
- Sits between the job-dispatch logic (start/finish/wait/resume strobes) and the status/interrupt block.

Parameters:
NUM_CH, 4, number of independent channels (>=1)
TIMEOUT_W, 8, width of each channel's wait counter
TIMEOUT, 16, cycles a channel may stay in WAIT before ERROR; legal range 1..2**TIMEOUT_W
CNT_W, $clog2(NUM_CH+1), width of o_busy_count (derived, do not override)

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  reset, asynchronous, active-high
i_start  input  NUM_CH  per-channel start strobe
i_finish  input  NUM_CH  per-channel finish strobe
i_wait  input  NUM_CH  per-channel wait request
i_resume  input  NUM_CH  per-channel resume from WAIT
i_clear  input  NUM_CH  per-channel clear of ERROR
o_state  output  4*NUM_CH  one-hot state; channel c occupies bits [4c+3:4c]
o_timeout  output  NUM_CH  one-cycle pulse per channel on entry to ERROR
o_err_any  output  1  OR of all channel ERROR bits
o_busy_count  output  CNT_W  number of channels currently in BUSY

Behaviour:
- Clock i_clk; reset i_rst, asynchronous, active-high.
- State encoding per channel: IDLE=4'b0001, BUSY=4'b0010, WAIT=4'b0100, ERROR=4'b1000.
- Reset values:
  - Every channel IDLE, so o_state = {NUM_CH{4'b0001}}.
  - All counters 0, o_timeout=0, o_err_any=0, o_busy_count=0.
  - Reset asserted mid-operation forces these values immediately, regardless of state or counter value.
- Transitions per channel, registered, 1-cycle latency (a strobe in cycle t gives the new state in cycle t+1):
  - IDLE: i_start -> BUSY; all other inputs ignored.
  - BUSY: i_finish -> IDLE; else i_wait -> WAIT; else stay. i_finish has priority over simultaneous i_wait. i_start ignored.
  - WAIT:
    - i_resume -> BUSY.
    - Else if counter == TIMEOUT-1 -> ERROR.
    - Else counter increments.
    - i_start/i_finish/i_wait ignored.
  - ERROR: sticky; i_clear -> IDLE. All other inputs ignored.
- i_clear is ignored outside ERROR.
- Wait counter:
  - Cleared to 0 on every entry into WAIT; increments once per cycle spent in WAIT.
  - Net effect: a channel shows WAIT for exactly TIMEOUT cycles, then ERROR.
  - i_resume in the final WAIT cycle (counter == TIMEOUT-1) wins: goes to BUSY, no timeout.
  - Counter value is don't-care outside WAIT; it must not wrap (the TIMEOUT range guarantees this).
- o_timeout[c]: registered; high exactly in the first cycle channel c shows ERROR, low otherwise.
- Illegal state (non-one-hot, e.g. from SEU or force): next state ERROR, counter 0, o_timeout pulses.
- o_err_any and o_busy_count: combinational from the registered states (same cycle as o_state, no extra latency).
  - o_busy_count is an unsigned popcount; it reaches NUM_CH without overflow.
- Channels are fully independent; simultaneous events on different channels are all honoured in the same cycle.
- Elaboration assertions: TIMEOUT >= 1, TIMEOUT <= 2**TIMEOUT_W, NUM_CH >= 1.

Test Plan (NUM_CH=2, TIMEOUT=4, TIMEOUT_W=3):
- Reset then idle 3 cycles -> o_state=8'h11, o_busy_count=0, o_err_any=0, o_timeout=0.
- ch0 i_start pulse at cycle t -> ch0 BUSY at t+1 (o_state=8'h12, busy_count=1); i_wait+i_finish together at t+2 -> IDLE at t+3 (finish priority).
- ch1 start, then wait, no resume -> WAIT visible for exactly 4 cycles, ERROR on 5th; o_timeout[1] high only that cycle; o_err_any stays 1; i_start ignored; i_clear -> IDLE next cycle, o_err_any=0.
- ch0 in WAIT, i_resume exactly in 4th WAIT cycle -> BUSY next cycle, no o_timeout.
- Re-enter WAIT after a resume -> counter restarts (4 full cycles again).
- Both channels started in same cycle -> o_busy_count=2.
- i_rst asserted asynchronously mid-WAIT (counter=2) -> o_state=8'h11 immediately, no o_timeout.
- Force ch0 state to 4'b0110 -> ERROR next cycle with o_timeout[0] pulse.

Source files
------------

// File: rtl/fsm_multi_timeout.sv
// Array of independent one-hot job-control FSMs (IDLE/BUSY/WAIT/ERROR) with a
// per-channel WAIT timeout, sticky ERROR, and aggregate busy/error status.

module fsm_mt_ch #(
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       start,
  input  logic       finish,
  input  logic       wait_req,
  input  logic       resume,
  input  logic       clear,
  output logic [3:0] state,
  output logic       timeout
);
  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_BUSY = 4'b0010,
    S_WAIT = 4'b0100,
    S_ERR  = 4'b1000
  } state_e;

  localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT - 1);

  // Kept as a plain vector so a corrupted (non-one-hot) value is representable.
  logic [3:0]           state_q;
  state_e               state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 tmo_q;

  always_comb begin
    state_d = S_ERR;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: state_d = start ? S_BUSY : S_IDLE;
      S_BUSY: begin
        if (finish)        state_d = S_IDLE;
        else if (wait_req) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
        else               state_d = S_BUSY;
      end
      S_WAIT: begin
        // Resume in the last WAIT cycle beats the timeout.
        if (resume)                 state_d = S_BUSY;
        else if (cnt_q == CNT_LAST) state_d = S_ERR;
        else begin
          state_d = S_WAIT;
          cnt_d   = cnt_q + TIMEOUT_W'(1);
        end
      end
      S_ERR:  state_d = clear ? S_IDLE : S_ERR;
      default: begin
        state_d = S_ERR;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= (state_d == S_ERR) && (state_q != S_ERR);
    end
  end

  assign state   = state_q;
  assign timeout = tmo_q;
endmodule

module fsm_multi_timeout #(
  parameter int NUM_CH    = 4,
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 16,
  parameter int CNT_W     = $clog2(NUM_CH + 1)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NUM_CH-1:0]   i_start,
  input  logic [NUM_CH-1:0]   i_finish,
  input  logic [NUM_CH-1:0]   i_wait,
  input  logic [NUM_CH-1:0]   i_resume,
  input  logic [NUM_CH-1:0]   i_clear,
  output logic [4*NUM_CH-1:0] o_state,
  output logic [NUM_CH-1:0]   o_timeout,
  output logic                o_err_any,
  output logic [CNT_W-1:0]    o_busy_count
);
  if (NUM_CH < 1 || TIMEOUT < 1 || TIMEOUT > (1 << TIMEOUT_W)) begin : g_param_chk
    $error("fsm_multi_timeout: illegal NUM_CH/TIMEOUT/TIMEOUT_W");
  end

  logic [NUM_CH-1:0] busy, err;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    fsm_mt_ch #(.TIMEOUT_W(TIMEOUT_W), .TIMEOUT(TIMEOUT)) u_ch (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .start   (i_start[c]),
      .finish  (i_finish[c]),
      .wait_req(i_wait[c]),
      .resume  (i_resume[c]),
      .clear   (i_clear[c]),
      .state   (o_state[4*c +: 4]),
      .timeout (o_timeout[c])
    );
    assign busy[c] = o_state[4*c+1];
    assign err[c]  = o_state[4*c+3];
  end

  assign o_err_any = |err;

  always_comb begin
    o_busy_count = '0;
    for (int c = 0; c < NUM_CH; c++)
      o_busy_count = o_busy_count + CNT_W'(busy[c]);
  end
endmodule

// File: tb/tb_fsm_multi_timeout.sv
// Table-driven directed vectors, hand-written reset/illegal-state sequences,
// then random stimulus compared against a cycle-level behavioural model.

module tb_fsm_multi_timeout;
  localparam int NUM_CH    = 2;
  localparam int TIMEOUT_W = 3;
  localparam int TIMEOUT   = 4;
  localparam int CNT_W     = 2;

  logic              i_clk, i_rst;
  logic [1:0]        i_start, i_finish, i_wait, i_resume, i_clear;
  logic [7:0]        o_state;
  logic [1:0]        o_timeout;
  logic              o_err_any;
  logic [CNT_W-1:0]  o_busy_count;

  int checks = 0;
  int errors = 0;

  fsm_multi_timeout #(.NUM_CH(NUM_CH), .TIMEOUT_W(TIMEOUT_W), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_start(i_start), .i_finish(i_finish), .i_wait(i_wait),
    .i_resume(i_resume), .i_clear(i_clear),
    .o_state(o_state), .o_timeout(o_timeout),
    .o_err_any(o_err_any), .o_busy_count(o_busy_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [1:0] st, fi, wt, rs, cl;
    logic [7:0] e_state;
    logic [1:0] e_busy;
    logic       e_err;
    logic [1:0] e_tmo;
  } vec_t;

  vec_t tbl[24];

  function automatic vec_t mk(logic [1:0] st, fi, wt, rs, cl,
                              logic [7:0] es, logic [1:0] eb, logic ee, logic [1:0] et);
    vec_t v;
    v.st = st; v.fi = fi; v.wt = wt; v.rs = rs; v.cl = cl;
    v.e_state = es; v.e_busy = eb; v.e_err = ee; v.e_tmo = et;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] es, input logic [1:0] eb,
                         input logic ee, input logic [1:0] et);
    chk({tag, " state"},   o_state, es);
    chk({tag, " busy"},    8'(o_busy_count), 8'(eb));
    chk({tag, " err_any"}, 8'(o_err_any), 8'(ee));
    chk({tag, " timeout"}, 8'(o_timeout), 8'(et));
  endtask

  task automatic drive(input logic [1:0] st, fi, wt, rs, cl);
    i_start = st; i_finish = fi; i_wait = wt; i_resume = rs; i_clear = cl;
  endtask

  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  // Behavioural model: 0=IDLE 1=BUSY 2=WAIT 3=ERROR; mw = WAIT cycles shown so far.
  int         mst[NUM_CH];
  int         mw[NUM_CH];
  logic [1:0] mtmo;

  task automatic m_reset();
    for (int c = 0; c < NUM_CH; c++) begin mst[c] = 0; mw[c] = 0; end
    mtmo = '0;
  endtask

  task automatic m_step(input logic [1:0] s, f, w, r, cl);
    for (int c = 0; c < NUM_CH; c++) begin
      mtmo[c] = 1'b0;
      case (mst[c])
        0: if (s[c]) mst[c] = 1;
        1: if (f[c]) mst[c] = 0;
           else if (w[c]) begin mst[c] = 2; mw[c] = 1; end
        2: if (r[c]) mst[c] = 1;
           else if (mw[c] == TIMEOUT) begin mst[c] = 3; mtmo[c] = 1'b1; end
           else mw[c]++;
        default: if (cl[c]) mst[c] = 0;
      endcase
    end
  endtask

  task automatic m_check(input string tag);
    logic [7:0] es;
    logic [1:0] eb;
    logic       ee;
    es = '0; eb = '0; ee = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      es = es | (8'd1 << (mst[c] + 4*c));
      if (mst[c] == 1) eb = eb + 2'd1;
      if (mst[c] == 3) ee = 1'b1;
    end
    chk_all(tag, es, eb, ee, mtmo);
  endtask

  initial begin
    logic [1:0] rs, rf, rw, rr, rc;

    tbl[0]  = mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 8'h11, 2'd0, 1'b0, 2'b00);
    tbl[1]  = mk(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 8'h12, 2'd1, 1'b0, 2'b00);
    tbl[2]  = mk(2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 8'h11, 2'd0, 1'b0, 2'b00);
    tbl[3]  = mk(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 8'h21, 2'd1, 1'b0, 2'b00);
    tbl[4]  = mk(2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 8'h41, 2'd0, 1'b0, 2'b00);
    tbl[5]  = mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 8'h41, 2'd0, 1'b0, 2'b00);
    tbl[6]  = mk(2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 8'h41, 2'd0, 1'b0, 2'b00);
    tbl[7]  = mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 8'h41, 2'd0, 1'b0, 2'b00);
    tbl[8]  = mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 8'h81, 2'd0, 1'b1, 2'b10);
    tbl[9]  = mk(2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 8'h81, 2'd0, 1'b1, 2'b00);
    tbl[10] = mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 8'h81, 2'd0, 1'b1, 2'b00);
    tbl[11] = mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 8'h11, 2'd0, 1'b0, 2'b00);
    tbl[12] = mk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 8'h22, 2'd2, 1'b0, 2'b00);
    tbl[13] = mk(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 8'h24, 2'd1, 1'b0, 2'b00);
    tbl[14] = mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 8'h24, 2'd1, 1'b0, 2'b00);
    tbl[15] = mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 8'h24, 2'd1, 1'b0, 2'b00);
    tbl[16] = mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 8'h24, 2'd1, 1'b0, 2'b00);
    tbl[17] = mk(2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 8'h22, 2'd2, 1'b0, 2'b00);
    tbl[18] = mk(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 8'h24, 2'd1, 1'b0, 2'b00);
    tbl[19] = mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 8'h24, 2'd1, 1'b0, 2'b00);
    tbl[20] = mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 8'h24, 2'd1, 1'b0, 2'b00);
    tbl[21] = mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 8'h24, 2'd1, 1'b0, 2'b00);
    tbl[22] = mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 8'h28, 2'd1, 1'b1, 2'b01);
    tbl[23] = mk(2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 8'h11, 2'd0, 1'b0, 2'b00);

    drive('0, '0, '0, '0, '0);
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    chk_all("in_reset", 8'h11, 2'd0, 1'b0, 2'b00);
    i_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("idle%0d", i), 8'h11, 2'd0, 1'b0, 2'b00);
    end

    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].st, tbl[i].fi, tbl[i].wt, tbl[i].rs, tbl[i].cl);
      tick();
      chk_all($sformatf("row%0d", i), tbl[i].e_state, tbl[i].e_busy, tbl[i].e_err, tbl[i].e_tmo);
    end

    // Async reset while ch0 sits in WAIT with counter at 2.
    drive(2'b01, '0, '0, '0, '0); tick();
    drive('0, '0, 2'b01, '0, '0); tick();
    drive('0, '0, '0, '0, '0);    tick(); tick();
    chk("pre_rst state", o_state, 8'h14);
    #2 i_rst = 1'b1;
    #1 chk_all("async_rst", 8'h11, 2'd0, 1'b0, 2'b00);
    tick();
    i_rst = 1'b0;
    tick();
    chk_all("post_rst", 8'h11, 2'd0, 1'b0, 2'b00);

    // Corrupt ch0 to a non-one-hot value.
    force dut.g_ch[0].u_ch.state_q = 4'b0110;
    #1 release dut.g_ch[0].u_ch.state_q;
    tick();
    chk_all("illegal", 8'h18, 2'd0, 1'b1, 2'b01);
    tick();
    chk_all("illegal_hold", 8'h18, 2'd0, 1'b1, 2'b00);

    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    m_reset();

    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        rs[c] = ($urandom_range(0, 2) == 0);
        rf[c] = ($urandom_range(0, 5) == 0);
        rw[c] = ($urandom_range(0, 1) == 0);
        rr[c] = ($urandom_range(0, 7) == 0);
        rc[c] = ($urandom_range(0, 3) == 0);
      end
      drive(rs, rf, rw, rr, rc);
      @(posedge i_clk);
      m_step(rs, rf, rw, rr, rc);
      @(negedge i_clk);
      m_check($sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
